matmul_seq_ctrl: RTL
====================

Name: matmul_seq_ctrl

Overview:
Top-level sequencer for the 3x3 (max) 4-bit matrix-multiply accelerator. It takes the matrix dimensions and a host element stream (valid/ready), clears the memory bank, and streams W and then X elements into it. It then waits for the bank's unload-complete indication and reports done or error to the host. It sits between the host interface and the memory bank/MAC array.

Parameters:
DATA_W, 4, element width; matches the bank data_in width.
CNT_W, 4, element/beat counter width; must hold 9.
TIMEOUT, 15, COMPUTE-state watchdog limit in cycles; used only with the optional feature.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a job; sampled only in IDLE
row_w  input  2  W rows
col_w  input  2  W cols
row_x  input  2  X rows
col_x  input  2  X cols
s_valid  input  1  host element valid
s_data  input  DATA_W  host element, row-major
s_ready  output  1  controller accepts element
mem_data  output  DATA_W  element to bank data_in
mem_we  output  1  element write strobe to bank
mem_clear  output  1  bank clear_mem
mem_dims  output  8  latched {row_w,col_w,row_x,col_x} to bank
unload_done  input  1  bank unload_res
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle job-complete pulse
err  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low. Reset forces state IDLE and all outputs to 0: s_ready, mem_data, mem_we, mem_clear, mem_dims, busy, done, err. All counters are cleared to 0.
- States: IDLE, CHECK, CLEAR, LOAD_W, LOAD_X, COMPUTE, DONE.
- IDLE: if start=1, latch the four dimensions into mem_dims, clear err, and go to CHECK. start is ignored in every other state.
- CHECK (1 cycle): error if any dimension is 0 or col_w != row_x. On error set err=1 and return to IDLE; done is not pulsed. Otherwise go to CLEAR.
- CLEAR (1 cycle): mem_clear=1. Load the beat counter with row_w*col_w, computed at 4-bit width with no overflow (max 9). Go to LOAD_W.
- LOAD_W / LOAD_X:
  - s_ready=1 combinationally while in these states.
  - A transfer occurs when s_valid and s_ready are both 1. Each transfer decrements the beat counter.
  - mem_data and mem_we are registered: mem_we=1 and mem_data=s_data one cycle after each transfer. mem_we is 0 otherwise and mem_data holds its value.
  - When the last W beat transfers, reload the counter with row_x*col_x and go to LOAD_X with no bubble, so s_ready stays high.
  - When the last X beat transfers, go to COMPUTE; s_ready drops in that same cycle.
  - s_valid low stalls indefinitely with no state change.
- COMPUTE: s_ready=0. Wait for unload_done=1, then go to DONE. unload_done is ignored in all other states.
- DONE (1 cycle): done=1, then go to IDLE. busy is 0 starting the cycle after DONE.
- Simultaneous events:
  - start asserted in DONE is ignored; the host must re-assert it in IDLE.
  - unload_done asserted in the same cycle as the last X transfer is ignored; COMPUTE needs unload_done sampled while in COMPUTE.
- Reset mid-job: immediate return to IDLE. No done pulse. A partial bank load is abandoned; the next job's CLEAR wipes it.
- 1x1 case: exactly one beat each for W and X.

Optional Feature:
Macro MATMUL_SEQ_CTRL_TIMEOUT_EN.
- Defined: a cycle counter runs in COMPUTE. If TIMEOUT cycles elapse without unload_done, set err=1, pulse mem_clear for 1 cycle, and go to IDLE with no done pulse. The counter clears on entering COMPUTE.
- Not defined: COMPUTE waits indefinitely and err is set only by CHECK.

Test Plan:
- Reset mid-LOAD_W after 3 beats (rst_n=0 for 1 cycle) -> busy=0, s_ready=0, mem_we=0 immediately; a new 2x2 job then runs normally.
- 3x3 by 3x3, s_valid held 1, unload_done asserted 4 cycles into COMPUTE -> mem_clear pulse; 18 consecutive mem_we pulses with data matching input order; done pulse 5 cycles after the 18th transfer; err=0.
- 2x3 by 3x1 with s_valid toggling every other cycle -> exactly 6 then 3 mem_we pulses; s_ready stays high across the W/X boundary; mem_dims=8'b10_11_11_01.
- Mismatch: col_w=2, row_x=3 -> err=1 two cycles after start; no mem_clear, s_ready never 1, no done. A following valid start clears err.
- start pulsed during LOAD_X and during DONE -> ignored; the job completes once and only one done is seen.
- With MATMUL_SEQ_CTRL_TIMEOUT_EN and TIMEOUT=15, unload_done held 0 -> err=1 and a mem_clear pulse 15 cycles after entering COMPUTE, then IDLE. Without the macro, still in COMPUTE after 100 cycles.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: host-side job sequencer for the 3x3 4-bit matmul engine.
// Checks dims, clears the bank, streams W then X, waits for unload, reports.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                job request (sampled in IDLE only)
//   row_w/col_w/row_x/col_x  matrix dimensions (2 bits each)
//   s_valid/s_data/s_ready   host element stream (valid/ready)
//   mem_data/mem_we      registered element write to bank
//   mem_clear            bank clear strobe
//   mem_dims             latched {row_w,col_w,row_x,col_x}
//   unload_done          bank unload complete
//   busy/done/err        status: not-idle, job-done pulse, sticky error
//
// Optional: define MATMUL_SEQ_CTRL_TIMEOUT_EN to add a COMPUTE watchdog
// that aborts the job after TIMEOUT cycles without unload_done.

module matmul_seq_ctrl #(
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        row_w,
    input  logic [1:0]        col_w,
    input  logic [1:0]        row_x,
    input  logic [1:0]        col_x,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_clear,
    output logic [7:0]        mem_dims,
    input  logic              unload_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_dims;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_we;

    logic              w_ready;
    logic              w_xfer;
    logic              w_bad;
    logic              w_last;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_nw;
    logic [CNT_W-1:0]  w_nx;

    assign w_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
    assign w_xfer  = s_valid && w_ready;

    assign w_bad = (r_dims[7:6] == 2'd0) || (r_dims[5:4] == 2'd0) ||
                   (r_dims[3:2] == 2'd0) || (r_dims[1:0] == 2'd0) ||
                   (r_dims[5:4] != r_dims[3:2]);

    // Beat counts; operands are 2-bit so the product never exceeds 9.
    assign w_nw = CNT_W'(r_dims[7:6]) * CNT_W'(r_dims[5:4]);
    assign w_nx = CNT_W'(r_dims[3:2]) * CNT_W'(r_dims[1:0]);

    // Counter counts down to 1; the beat taken at 1 is the last one.
    assign w_last = (r_cnt == CNT_W'(1));

`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT + 1);

    logic [TC_W-1:0] r_tcnt;

    // r_tcnt equals the number of COMPUTE cycles already elapsed.
    assign w_timeout = (r_state == S_COMPUTE) && !unload_done &&
                       (r_tcnt == TC_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state != S_COMPUTE) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TC_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_bad ? S_IDLE : S_CLEAR;
            end
            S_CLEAR: begin
                w_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (w_xfer && w_last) begin
                    w_next = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                if (w_xfer && w_last) begin
                    w_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (unload_done) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        s_ready   = 1'b0;
        mem_clear = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        s_ready   = w_ready;
        mem_clear = (r_state == S_CLEAR) || w_timeout;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
    end

    // Datapath: dims latch, error flag, beat counter, bank write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dims     <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= w_xfer;
            if (w_xfer) begin
                r_mem_data <= s_data;
            end
            if (r_state == S_IDLE && start) begin
                r_dims <= {row_w, col_w, row_x, col_x};
                r_err  <= 1'b0;
            end
            if (r_state == S_CHECK && w_bad) begin
                r_err <= 1'b1;
            end
            if (w_timeout && !unload_done) begin
                r_err <= 1'b1;
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= w_nw;
            end else if (w_xfer) begin
                if (r_state == S_LOAD_W && w_last) begin
                    r_cnt <= w_nx;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign mem_dims = r_dims;
    assign err      = r_err;

endmodule
